// File: rtl/lcd_frame_sequencer.sv
// rtl/lcd_frame_sequencer.sv - two-line text frame buffer streamed to an HD44780 controller
module lcd_frame_sequencer #(
    parameter int          COLS       = 16,
    parameter logic [7:0]  LINE1_CMD  = 8'h80,
    parameter logic [7:0]  LINE2_CMD  = 8'hC0,
    parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Init_Done,
    input  logic       Wr_En,
    input  logic [4:0] Wr_Addr,
    input  logic [7:0] Wr_Data,
    input  logic       Refresh,
    output logic       Out_Valid,
    output logic       Out_Rs,
    output logic [7:0] Out_Data,
    input  logic       Out_Ready,
    output logic       Busy,
    output logic       Frame_Done
);

    typedef enum logic [2:0] {
        WAIT_INIT, IDLE, SET_L1, CHARS_L1, SET_L2, CHARS_L2, DONE
    } state_t;

    localparam logic [3:0] LAST_COL = 4'(COLS - 1);

    state_t     state_q;
    logic [3:0] col_q;
    logic       pending_q;
    logic       valid_q;
    logic       rs_q;
    logic [7:0] data_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] buf_q [0:31];

    logic wr_ok;
    logic xfer;

    assign wr_ok = Wr_En && ({1'b0, Wr_Addr[3:0]} < 5'(COLS));
    assign xfer  = valid_q && Out_Ready;

    assign Out_Valid  = valid_q;
    assign Out_Rs     = rs_q;
    assign Out_Data   = data_q;
    assign Busy       = busy_q;
    assign Frame_Done = done_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) buf_q[i] <= BLANK_CHAR;
        end else if (wr_ok) begin
            buf_q[Wr_Addr] <= Wr_Data;
        end
    end

    // Columns are read from the buffer at the edge a beat is loaded, so a
    // write lands in the current frame only if its column is still ahead.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= WAIT_INIT;
            col_q     <= 4'd0;
            pending_q <= 1'b1;
            valid_q   <= 1'b0;
            rs_q      <= 1'b0;
            data_q    <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            pending_q <= wr_ok || Refresh || (pending_q && state_q != IDLE);
            case (state_q)
                WAIT_INIT: if (Init_Done) state_q <= IDLE;
                IDLE: if (pending_q) begin
                    state_q <= SET_L1;
                    valid_q <= 1'b1;
                    rs_q    <= 1'b0;
                    data_q  <= LINE1_CMD;
                    busy_q  <= 1'b1;
                end
                SET_L1: if (xfer) begin
                    state_q <= CHARS_L1;
                    col_q   <= 4'd0;
                    rs_q    <= 1'b1;
                    data_q  <= buf_q[5'd0];
                end
                CHARS_L1: if (xfer) begin
                    if (col_q == LAST_COL) begin
                        state_q <= SET_L2;
                        rs_q    <= 1'b0;
                        data_q  <= LINE2_CMD;
                    end else begin
                        col_q  <= col_q + 4'd1;
                        data_q <= buf_q[{1'b0, col_q + 4'd1}];
                    end
                end
                SET_L2: if (xfer) begin
                    state_q <= CHARS_L2;
                    col_q   <= 4'd0;
                    rs_q    <= 1'b1;
                    data_q  <= buf_q[5'd16];
                end
                CHARS_L2: if (xfer) begin
                    if (col_q == LAST_COL) begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        col_q  <= col_q + 4'd1;
                        data_q <= buf_q[{1'b1, col_q + 4'd1}];
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= WAIT_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// tb/tb_lcd_frame_sequencer.sv - scoreboard bench for lcd_frame_sequencer
module tb_lcd_frame_sequencer;

    localparam int COLS = 16;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Init_Done;
    logic       Wr_En;
    logic [4:0] Wr_Addr;
    logic [7:0] Wr_Data;
    logic       Refresh;
    logic       Out_Valid;
    logic       Out_Rs;
    logic [7:0] Out_Data;
    logic       Out_Ready = 1'b1;
    logic       Busy;
    logic       Frame_Done;

    logic       init8, w8_en, v8, rs8, busy8, fd8;
    logic [4:0] w8_addr;
    logic [7:0] w8_data, d8;

    lcd_frame_sequencer #(.COLS(COLS)) u_dut (
        .Clock(Clock), .Reset(Reset), .Init_Done(Init_Done),
        .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Refresh(Refresh),
        .Out_Valid(Out_Valid), .Out_Rs(Out_Rs), .Out_Data(Out_Data),
        .Out_Ready(Out_Ready), .Busy(Busy), .Frame_Done(Frame_Done)
    );

    lcd_frame_sequencer #(.COLS(8)) u_dut8 (
        .Clock(Clock), .Reset(Reset), .Init_Done(init8),
        .Wr_En(w8_en), .Wr_Addr(w8_addr), .Wr_Data(w8_data), .Refresh(1'b0),
        .Out_Valid(v8), .Out_Rs(rs8), .Out_Data(d8),
        .Out_Ready(1'b1), .Busy(busy8), .Frame_Done(fd8)
    );

    always #10 Clock = ~Clock;

    int         checks = 0;
    int         errors = 0;
    int         xfer_count = 0;
    int         ready_mode = 1;   // 0 random, 1 held high, 2 held low
    logic [9:0] sb [$];           // bit 9 marks the Frame_Done slot
    logic [7:0] mbuf [0:31];
    int         x8 = 0;
    logic [8:0] cap8 [0:63];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Reference frame: command, line 1 text, command, line 2 text, done pulse.
    task automatic push_frame();
        sb.push_back(10'h080);
        for (int c = 0; c < COLS; c++) sb.push_back({2'b01, mbuf[c]});
        sb.push_back(10'h0C0);
        for (int c = 0; c < COLS; c++) sb.push_back({2'b01, mbuf[16 + c]});
        sb.push_back(10'h200);
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        Wr_En = 1'b1; Wr_Addr = a; Wr_Data = d;
        mbuf[a] = d;
        tick();
        Wr_En = 1'b0;
    endtask

    task automatic pulse_refresh();
        Refresh = 1'b1;
        tick();
        Refresh = 1'b0;
    endtask

    task automatic wait_xfer(input int target);
        int n = 0;
        while (xfer_count < target && n < 3000) begin tick(); n++; end
        check("xfer_wait_timeout", 32'(n < 3000), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 5000) begin tick(); n++; end
        check("drain_timeout", 32'(n < 5000), 32'd1);
        repeat (10) tick();
        check("idle_busy", 32'(Busy), 32'd0);
        check("idle_valid", 32'(Out_Valid), 32'd0);
    endtask

    // Writes issued while Out_Ready is low all land before any column is
    // loaded; any write after the start edge re-arms one more frame.
    task automatic burst(input logic [12:0] ws [$], input int rmode);
        ready_mode = 2;
        repeat (2) tick();
        foreach (ws[i]) wr(ws[i][12:8], ws[i][7:0]);
        push_frame();
        if (ws.size() > 1) push_frame();
        ready_mode = rmode;
        wait_idle();
    endtask

    initial begin
        forever begin
            @(posedge Clock);
            #1;
            if (ready_mode == 0)      Out_Ready = 1'($urandom_range(0, 1));
            else if (ready_mode == 1) Out_Ready = 1'b1;
            else                      Out_Ready = 1'b0;
        end
    end

    initial begin
        logic       stall_prev = 1'b0;
        logic       fd_prev = 1'b0;
        logic [8:0] held = '0;
        logic [9:0] exp;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                stall_prev = 1'b0;
                fd_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    checks++;
                    if (!Out_Valid || {Out_Rs, Out_Data} != held) begin
                        errors++;
                        $display("FAIL hold: valid=%0b beat=%h required valid=1 beat=%h",
                                 Out_Valid, {Out_Rs, Out_Data}, held);
                    end
                end
                stall_prev = Out_Valid && !Out_Ready;
                held = {Out_Rs, Out_Data};
                if (Out_Valid && !Busy) begin
                    checks++; errors++;
                    $display("FAIL busy_with_valid: busy=0 required 1");
                end
                if (Out_Valid && Out_Ready) begin
                    xfer_count++;
                    checks++;
                    if (sb.size() == 0 || sb[0][9]) begin
                        errors++;
                        $display("FAIL unexpected_beat: got %h required none", {Out_Rs, Out_Data});
                    end else begin
                        exp = sb.pop_front();
                        if (exp[8:0] != {Out_Rs, Out_Data}) begin
                            errors++;
                            $display("FAIL beat %0d: got rs/data %h required %h",
                                     xfer_count, {Out_Rs, Out_Data}, exp[8:0]);
                        end
                    end
                end
                if (Frame_Done) begin
                    checks++;
                    if (sb.size() == 0 || !sb[0][9] || Out_Valid || fd_prev) begin
                        errors++;
                        $display("FAIL frame_done: valid=%0b prev=%0b queued=%0d required done slot",
                                 Out_Valid, fd_prev, sb.size());
                    end else begin
                        void'(sb.pop_front());
                    end
                end
                fd_prev = Frame_Done;
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clock);
            if (!Reset && v8) begin
                if (x8 < 64) cap8[x8] = {rs8, d8};
                x8++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] q [$];
        int base;
        int vseen;
        Reset = 1'b1; Init_Done = 1'b0; Wr_En = 1'b0; Wr_Addr = '0; Wr_Data = '0;
        Refresh = 1'b0; init8 = 1'b0; w8_en = 1'b0; w8_addr = '0; w8_data = '0;
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
        repeat (3) tick();
        check("rst_valid", 32'(Out_Valid), 32'd0);
        check("rst_rs", 32'(Out_Rs), 32'd0);
        check("rst_data", 32'(Out_Data), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Frame_Done), 32'd0);
        Reset = 1'b0;

        vseen = 0;
        for (int i = 0; i < 100; i++) begin tick(); if (Out_Valid) vseen++; end
        check("wait_init_valid", 32'(vseen), 32'd0);
        push_frame();
        Init_Done = 1'b1;
        init8 = 1'b1;
        wait_idle();
        check("first_frame_xfers", 32'(xfer_count), 32'd34);

        check("cols8_first_frame", 32'(x8), 32'd18);
        w8_en = 1'b1; w8_addr = 5'h0F; w8_data = 8'h58;
        tick();
        w8_en = 1'b0;
        repeat (40) tick();
        check("cols8_ignored_write", 32'(x8), 32'd18);
        w8_en = 1'b1; w8_addr = 5'h07; w8_data = 8'h51;
        tick();
        w8_en = 1'b0;
        repeat (60) tick();
        check("cols8_second_frame", 32'(x8), 32'd36);
        check("cols8_cmd1", 32'(cap8[18]), 32'h080);
        check("cols8_last_col", 32'(cap8[26]), 32'h151);
        check("cols8_cmd2", 32'(cap8[27]), 32'h0C0);
        check("cols8_l2_end", 32'(cap8[35]), 32'h120);

        q.delete();
        q.push_back({5'h00, 8'h41});
        q.push_back({5'h1F, 8'h5A});
        burst(q, 1);

        for (int it = 0; it < 6; it++) begin
            q.delete();
            for (int j = 0; j < int'($urandom_range(1, 4)); j++) q.push_back(13'($urandom));
            burst(q, it % 2);
        end

        ready_mode = 1;
        push_frame();
        base = xfer_count;
        pulse_refresh();
        wait_xfer(base + 19);
        wr(5'h03, 8'h6B);
        push_frame();
        wait_idle();

        push_frame();
        Refresh = 1'b1;
        tick();
        Refresh = 1'b0;
        check("refresh_pending_cycle", 32'(Out_Valid), 32'd0);
        tick();
        check("refresh_latency", 32'(Out_Valid), 32'd1);
        wait_idle();

        ready_mode = 0;
        push_frame();
        base = xfer_count;
        pulse_refresh();
        wait_xfer(base + 10);
        pulse_refresh();
        pulse_refresh();
        push_frame();
        wait_idle();

        ready_mode = 1;
        Wr_En = 1'b1; Wr_Addr = 5'h12; Wr_Data = 8'h3F; Refresh = 1'b1;
        mbuf[5'h12] = 8'h3F;
        tick();
        Wr_En = 1'b0; Refresh = 1'b0;
        push_frame();
        wait_idle();

        push_frame();
        base = xfer_count;
        pulse_refresh();
        wait_xfer(base + 5);
        #2;
        Reset = 1'b1;
        #1;
        check("midreset_valid", 32'(Out_Valid), 32'd0);
        check("midreset_busy", 32'(Busy), 32'd0);
        check("midreset_done", 32'(Frame_Done), 32'd0);
        sb.delete();
        Init_Done = 1'b0;
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
        repeat (3) tick();
        Reset = 1'b0;
        vseen = 0;
        for (int i = 0; i < 30; i++) begin tick(); if (Out_Valid) vseen++; end
        check("reset_wait_init", 32'(vseen), 32'd0);
        push_frame();
        Init_Done = 1'b1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
